// File: rtl/mpsoc_trace_supervisor_pkg.sv
// Shared definitions for the MPSoC trace supervisor.
// Contents: simulation-control NOP encoding, NOP immediate codes,
// supervisor state enum, putc character record and a NOP decode helper.
// Optional putc path is enabled by macro TRACE_SUPERVISOR_PUTC_EN.
package mpsoc_trace_supervisor_pkg;

   // addi x0,x0,K with the immediate stripped: insn[19:0]
   localparam logic [19:0] NOP_OPCODE = 20'h00013;
   localparam logic [11:0] NOP_EXIT   = 12'd1;
   localparam logic [11:0] NOP_PUTC   = 12'd4;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DONE,
      ST_TIMEOUT
   } sup_state_t;

   // Core index is carried at a fixed 8-bit width and narrowed at the port.
   typedef struct packed {
      logic [7:0] core;
      logic [7:0] data;
   } char_rec_t;

   function automatic logic is_nop_k(input logic [31:0] insn, input logic [11:0] k);
      return (insn[19:0] == NOP_OPCODE) && (insn[31:20] == k);
   endfunction

endpackage

// File: rtl/mpsoc_trace_supervisor_fifo.sv
// Generic synchronous FIFO with full/empty flags, used for the putc
// character stream when TRACE_SUPERVISOR_PUTC_EN is defined.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_push, i_wdata write request and data (accepted when not full, or
//                   when full and popping in the same cycle)
//   o_full          FIFO holds DEPTH entries
//   i_pop           read request (ignored when empty)
//   o_rdata         head entry (valid when !o_empty)
//   o_empty         FIFO holds no entries
module mpsoc_trace_supervisor_fifo
   import mpsoc_trace_supervisor_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   output logic             o_full,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wp;
   logic [AW:0]      r_rp;
   logic             w_do_push;
   logic             w_do_pop;

   // Extra pointer MSB distinguishes full from empty when indices match.
   assign o_empty   = (r_wp == r_rp);
   assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || i_pop);
   assign o_rdata   = r_mem[r_rp[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_do_push) r_wp <= r_wp + 1'b1;
         if (w_do_pop)  r_rp <= r_rp + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wp[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/mpsoc_trace_supervisor.sv
// Trace supervisor for NUM_CORES compute tiles. Per core it shadows x3,
// decodes simulation-control NOPs (exit, optionally putc) and latches the
// exit code; globally it counts cycles in RUN and runs a timeout watchdog.
// Optional putc character path: define TRACE_SUPERVISOR_PUTC_EN.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   trace_*          per-core retirement bundle (valid, wben, wbreg, wbdata, insn)
//   timeout_limit    watchdog limit, 0 disables
//   terminated       sticky per-core exit flag
//   exit_code        per-core x3 value captured at exit
//   all_done         every core terminated (DONE state)
//   any_fail         some terminated core has a nonzero exit code
//   timeout          watchdog expired (TIMEOUT state)
//   cycle_count      saturating count of cycles spent in RUN
//   char_*           (macro only) putc stream with valid/ready, overflow flag
module mpsoc_trace_supervisor
   import mpsoc_trace_supervisor_pkg::*;
#(
   parameter int NUM_CORES  = 4,
   parameter int XLEN       = 32,
   parameter int CNT_W      = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CORES-1:0]      trace_valid,
   input  logic [NUM_CORES-1:0]      trace_wben,
   input  logic [NUM_CORES*5-1:0]    trace_wbreg,
   input  logic [NUM_CORES*XLEN-1:0] trace_wbdata,
   input  logic [NUM_CORES*32-1:0]   trace_insn,
   input  logic [CNT_W-1:0]          timeout_limit,
   output logic [NUM_CORES-1:0]      terminated,
   output logic [NUM_CORES*XLEN-1:0] exit_code,
   output logic                      all_done,
   output logic                      any_fail,
   output logic                      timeout,
   output logic [CNT_W-1:0]          cycle_count
`ifdef TRACE_SUPERVISOR_PUTC_EN
   ,
   output logic                      char_valid,
   input  logic                      char_ready,
   output logic [7:0]                char_data,
   output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] char_core,
   output logic                      char_overflow
`endif
);

   logic [NUM_CORES-1:0][XLEN-1:0] r_x3;
   logic [NUM_CORES-1:0][XLEN-1:0] r_exit;
   logic [NUM_CORES-1:0]           r_term;
   logic [NUM_CORES-1:0]           w_exit;
   logic [NUM_CORES-1:0]           w_x3_wr;
   sup_state_t                     r_state;
   sup_state_t                     w_state_nxt;
   logic [CNT_W-1:0]               r_cnt;
   logic [CNT_W-1:0]               w_cnt_nxt;
   logic                           w_all_next;
   logic                           w_fail;

   // ---------------- per-core decode ----------------
`ifdef TRACE_SUPERVISOR_PUTC_EN
   logic [NUM_CORES-1:0] w_putc;
`endif

   always_comb begin
      w_exit  = '0;
      w_x3_wr = '0;
`ifdef TRACE_SUPERVISOR_PUTC_EN
      w_putc  = '0;
`endif
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         // terminated cores are silenced entirely
         if (trace_valid[i] && !r_term[i]) begin
            w_x3_wr[i] = trace_wben[i] && (trace_wbreg[i*5 +: 5] == 5'd3);
            w_exit[i]  = is_nop_k(trace_insn[i*32 +: 32], NOP_EXIT);
`ifdef TRACE_SUPERVISOR_PUTC_EN
            w_putc[i]  = is_nop_k(trace_insn[i*32 +: 32], NOP_PUTC);
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x3   <= '0;
         r_exit <= '0;
         r_term <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (w_x3_wr[i]) r_x3[i] <= trace_wbdata[i*XLEN +: XLEN];
            if (w_exit[i]) begin
               r_term[i] <= 1'b1;
               r_exit[i] <= r_x3[i];
            end
         end
      end
   end

   always_comb begin
      w_fail = 1'b0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         w_fail = w_fail | (r_term[i] && (r_exit[i] != '0));
      end
   end

   // ---------------- run / done / timeout FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // The watchdog is held off when this cycle's exits complete the set, so a
   // final exit coinciding with the limit still ends in DONE, never TIMEOUT.
   // The counter only advances on edges that stay in RUN.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_all_next  = &(r_term | w_exit);
      case (r_state)
         ST_RUN: begin
            if (&r_term) begin
               w_state_nxt = ST_DONE;
            end else if ((timeout_limit != '0) && (r_cnt == timeout_limit) && !w_all_next) begin
               w_state_nxt = ST_TIMEOUT;
            end else if (r_cnt != '1) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign terminated  = r_term;
   assign exit_code   = r_exit;
   assign all_done    = (r_state == ST_DONE);
   assign timeout     = (r_state == ST_TIMEOUT);
   assign any_fail    = w_fail;
   assign cycle_count = r_cnt;

   // ---------------- optional putc path ----------------
`ifdef TRACE_SUPERVISOR_PUTC_EN
   localparam int unsigned CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   logic [NUM_CORES-1:0]        r_pend_v;
   logic [NUM_CORES-1:0][7:0]   r_pend_d;
   logic [CORE_W-1:0]           r_rr;
   logic                        r_ovf;
   logic                        w_gnt_v;
   logic [CORE_W-1:0]           w_gnt_idx;
   logic                        w_push;
   logic                        w_pop;
   logic                        w_full;
   logic                        w_empty;
   char_rec_t                   w_push_rec;
   char_rec_t                   w_head;

   // Round-robin: first pending core at or after the pointer.
   always_comb begin
      w_gnt_v   = 1'b0;
      w_gnt_idx = '0;
      for (int unsigned k = 0; k < NUM_CORES; k++) begin
         int unsigned idx;
         idx = (32'(r_rr) + k) % NUM_CORES;
         if (!w_gnt_v && r_pend_v[idx]) begin
            w_gnt_v   = 1'b1;
            w_gnt_idx = CORE_W'(idx);
         end
      end
   end

   assign w_push = w_gnt_v && !w_full;
   assign w_pop  = !w_empty && char_ready;

   always_comb begin
      w_push_rec      = '0;
      w_push_rec.core = 8'(w_gnt_idx);
      w_push_rec.data = r_pend_d[w_gnt_idx];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend_v <= '0;
         r_pend_d <= '0;
         r_rr     <= '0;
         r_ovf    <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (w_push && (32'(w_gnt_idx) == i)) r_pend_v[i] <= 1'b0;
            if (w_putc[i]) begin
               if (r_pend_v[i]) begin
                  r_ovf <= 1'b1;
               end else begin
                  r_pend_v[i] <= 1'b1;
                  r_pend_d[i] <= r_x3[i][7:0];
               end
            end
         end
         if (w_push) begin
            if (32'(w_gnt_idx) == NUM_CORES - 1) r_rr <= '0;
            else                                  r_rr <= w_gnt_idx + 1'b1;
         end
      end
   end

   mpsoc_trace_supervisor_fifo #(
      .WIDTH ($bits(char_rec_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata (w_push_rec),
      .o_full  (w_full),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_empty (w_empty)
   );

   assign char_valid    = !w_empty;
   assign char_data     = w_head.data;
   assign char_core     = CORE_W'(w_head.core);
   assign char_overflow = r_ovf;
`endif

endmodule
